// File: rtl/effect_mixer.sv
// Sums NUM_CH signed 16-bit effect samples per playback tick, saturates to 16 bits,
// and serializes the held result MSB-first to the WM8731 DAC in I2S framing.
module effect_mixer #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sample_valid,
  input  logic [NUM_CH*16-1:0] i_samples,
  input  logic                 i_AUD_BCLK,
  input  logic                 i_AUD_DACLRCK,
  output logic                 o_AUD_DACDAT,
  output logic [15:0]          o_mix,
  output logic                 o_mix_valid,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic                 o_dropped
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StSat} state_e;

  state_e                state_q, state_d;
  logic [NUM_CH*16-1:0]  samples_q, samples_d;
  logic signed [19:0]    acc_q, acc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [15:0]           mix_q, mix_d;
  logic                  mix_valid_q, mix_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  dropped_q, dropped_d;
  logic [15:0]           hold_q, hold_d;

  logic [15:0]           cur_sample;
  logic [15:0]           sat_val;
  logic                  clamp;

  assign cur_sample = samples_q[idx_q*16 +: 16];

  always_comb begin
    sat_val = acc_q[15:0];
    clamp   = 1'b0;
    if (acc_q > 20'sd32767) begin
      sat_val = 16'h7fff;
      clamp   = 1'b1;
    end else if (acc_q < -20'sd32768) begin
      sat_val = 16'h8000;
      clamp   = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    samples_d   = samples_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    overflow_d  = overflow_q;
    dropped_d   = dropped_q;
    hold_d      = hold_q;
    unique case (state_q)
      StIdle: begin
        if (i_sample_valid) begin
          samples_d = i_samples;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = StAccum;
        end
      end
      StAccum: begin
        if (i_sample_valid) dropped_d = 1'b1;
        acc_d = acc_q + {{4{cur_sample[15]}}, cur_sample};
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) state_d = StSat;
      end
      StSat: begin
        if (i_sample_valid) dropped_d = 1'b1;
        mix_d       = sat_val;
        hold_d      = sat_val;
        mix_valid_d = 1'b1;
        if (clamp) overflow_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      samples_q   <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      dropped_q   <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      samples_q   <= samples_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      overflow_q  <= overflow_d;
      dropped_q   <= dropped_d;
      hold_q      <= hold_d;
    end
  end

  assign o_mix       = mix_q;
  assign o_mix_valid = mix_valid_q;
  assign o_busy      = (state_q != StIdle);
  assign o_overflow  = overflow_q;
  assign o_dropped   = dropped_q;

  // Codec clocks are asynchronous: 2-flop synchronizers plus one delay flop for edges.
  logic [1:0]  bclk_sync_q, lrck_sync_q;
  logic        bclk_prev_q, lrck_prev_q;
  logic        lrck_edge, bclk_fall;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dat_q, dat_d;

  assign lrck_edge = lrck_sync_q[1] ^ lrck_prev_q;
  assign bclk_fall = bclk_prev_q & ~bclk_sync_q[1];

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    if (lrck_edge) begin
      // Frame load wins over a coincident BCLK fall, giving the I2S one-bit delay.
      shift_d = hold_q;
      cnt_d   = '0;
    end else if (bclk_fall) begin
      if (cnt_q < 5'd16) begin
        dat_d   = shift_q[15];
        shift_d = {shift_q[14:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      dat_q       <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], i_AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], i_AUD_DACLRCK};
      bclk_prev_q <= bclk_sync_q[1];
      lrck_prev_q <= lrck_sync_q[1];
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dat_q       <= dat_d;
    end
  end

  assign o_AUD_DACDAT = dat_q;

endmodule

// File: tb/tb_effect_mixer.sv
// Self-checking bench for effect_mixer: mix latency/saturation/drop behaviour and I2S framing,
// using scoreboard queues for expected and captured mixes and DAC frames.
`timescale 1ns/1ps
module tb_effect_mixer;

  localparam int unsigned NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [63:0] samples = '0;
  logic        bclk = 1'b0;
  logic        lrck = 1'b0;
  logic        dacdat;
  logic [15:0] mix;
  logic        mix_valid, busy, overflow, dropped;

  effect_mixer #(.NUM_CH(NUM_CH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sample_valid(sample_valid),
    .i_samples     (samples),
    .i_AUD_BCLK    (bclk),
    .i_AUD_DACLRCK (lrck),
    .o_AUD_DACDAT  (dacdat),
    .o_mix         (mix),
    .o_mix_valid   (mix_valid),
    .o_busy        (busy),
    .o_overflow    (overflow),
    .o_dropped     (dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] exp_mix_q[$];
  logic [15:0] act_mix_q[$];
  logic [31:0] act_frame_q[$];

  bit          codec_en = 0;
  bit          aligned = 0;
  int          div = 0;
  int          falls = 0;
  logic [31:0] frame = '0;

  localparam logic [15:0] N30K = 16'h8ad0;  // -30000

  always @(negedge clk) if (rst_n && mix_valid) act_mix_q.push_back(mix);

  // Codec model: BCLK = clk/8, LRCK toggles on every 32nd BCLK falling edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (codec_en) begin
      div++;
      if (div == 4) begin
        div  = 0;
        bclk = ~bclk;
        if (bclk) begin
          if (aligned) begin
            frame = {frame[30:0], dacdat};
            if (falls == 31) act_frame_q.push_back(frame);
          end
        end else begin
          falls++;
          if (falls == 32) begin
            falls   = 0;
            lrck    = ~lrck;
            aligned = 1;
          end
        end
      end
    end
  end

  function automatic logic [15:0] model_mix(input logic [63:0] s);
    int sum = 0;
    logic signed [15:0] v;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      v = s[k*16 +: 16];
      sum += int'(v);
    end
    if (sum > 32767) return 16'h7fff;
    if (sum < -32768) return 16'h8000;
    return sum[15:0];
  endfunction

  function automatic logic [31:0] frame_of(input logic [15:0] v);
    return {1'b0, v, 15'b0};
  endfunction

  task automatic drive_pulse(input logic [63:0] s);
    @(negedge clk);
    samples      = s;
    sample_valid = 1'b1;
    exp_mix_q.push_back(model_mix(s));
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_mix();
    int n = 0;
    while (act_mix_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_frames(input int count, input int budget);
    int n = 0;
    while (act_frame_q.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mix, mix_valid, busy, overflow, dropped, dacdat} !== 21'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {mix, mix_valid, busy, overflow, dropped, dacdat});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n = 1;
    logic [15:0] a, e;
    drive_pulse({16'd0, 16'd25, 16'hffce, 16'd100});
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_pulse: got %b, expected 1", busy); end
    while (mix_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 6) begin n_fail++; $display("FAIL latency: got %0d, expected 6", n); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_valid: got %b, expected 0", busy); end
    wait_mix();
    n_cmp++;
    if (act_mix_q.size() == 0) begin
      n_fail++;
      $display("FAIL mix_basic: got no o_mix_valid, expected 75");
    end else begin
      a = act_mix_q.pop_front();
      e = exp_mix_q.pop_front();
      if (a !== e || a !== 16'd75) begin
        n_fail++;
        $display("FAIL mix_basic: got %0d, expected %0d", a, e);
      end
    end
    n_cmp++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_basic: got %b, expected 0", overflow); end
  endtask

  task automatic test_saturation();
    logic [15:0] a, e;
    logic [63:0] pats [2];
    logic [15:0] want [2];
    pats[0] = {16'd0, 16'd0, 16'd30000, 16'd30000};
    pats[1] = {16'd0, N30K, N30K, N30K};
    want[0] = 16'h7fff;
    want[1] = 16'h8000;
    for (int i = 0; i < 2; i++) begin
      drive_pulse(pats[i]);
      wait_mix();
      n_cmp++;
      if (act_mix_q.size() == 0) begin
        n_fail++;
        $display("FAIL mix_sat%0d: got no o_mix_valid, expected %h", i, want[i]);
      end else begin
        a = act_mix_q.pop_front();
        e = exp_mix_q.pop_front();
        if (a !== e || a !== want[i]) begin
          n_fail++;
          $display("FAIL mix_sat%0d: got %h, expected %h", i, a, want[i]);
        end
      end
      n_cmp++;
      if (overflow !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_sat%0d: got %b, expected 1", i, overflow);
      end
    end
  endtask

  task automatic test_dropped();
    logic [15:0] a, e;
    n_cmp++;
    if (dropped !== 1'b0) begin n_fail++; $display("FAIL dropped_pre: got %b, expected 0", dropped); end
    drive_pulse({16'd4000, 16'd3000, 16'd2000, 16'd1000});
    repeat (2) @(negedge clk);
    samples      = {16'd1, 16'd1, 16'd1, 16'd1};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_mix();
    n_cmp++;
    if (act_mix_q.size() == 0) begin
      n_fail++;
      $display("FAIL mix_drop: got no o_mix_valid, expected 10000");
    end else begin
      a = act_mix_q.pop_front();
      e = exp_mix_q.pop_front();
      if (a !== e || a !== 16'd10000) begin
        n_fail++;
        $display("FAIL mix_drop: got %0d, expected %0d", a, e);
      end
    end
    n_cmp++;
    if (dropped !== 1'b1) begin n_fail++; $display("FAIL dropped_flag: got %b, expected 1", dropped); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (act_mix_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_no_second: got %0d extra pulses busy=%b, expected 0", act_mix_q.size(), busy);
    end
  endtask

  task automatic check_mix_value(input logic [15:0] want);
    // Drives nothing and compares nothing: plain helper to drain a known-good mix.
    wait_mix();
  endtask

  task automatic test_framing();
    logic [15:0] a;
    logic [31:0] f;
    drive_pulse({16'd0, 16'd0, 16'd0, 16'ha5c3});
    wait_mix();
    n_cmp++;
    if (act_mix_q.size() == 0) begin
      n_fail++;
      $display("FAIL mix_a5c3: got no o_mix_valid, expected a5c3");
    end else begin
      a = act_mix_q.pop_front();
      void'(exp_mix_q.pop_front());
      if (a !== 16'ha5c3) begin n_fail++; $display("FAIL mix_a5c3: got %h, expected a5c3", a); end
    end
    act_frame_q.delete();
    falls    = 0;
    div      = 0;
    aligned  = 0;
    codec_en = 1;
    wait_frames(2, 3000);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (act_frame_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_phase%0d: got no frame, expected %h", i, frame_of(16'ha5c3));
      end else begin
        f = act_frame_q.pop_front();
        if (f !== frame_of(16'ha5c3)) begin
          n_fail++;
          $display("FAIL frame_phase%0d: got %h, expected %h", i, f, frame_of(16'ha5c3));
        end
      end
    end
  endtask

  task automatic test_midframe();
    int n = 0;
    logic [15:0] a;
    logic [31:0] f;
    while (!(aligned && falls == 8) && n < 600) begin
      @(negedge clk);
      n++;
    end
    act_frame_q.delete();
    drive_pulse({16'd0, 16'd0, 16'h0234, 16'h1000});
    wait_mix();
    n_cmp++;
    if (act_mix_q.size() == 0) begin
      n_fail++;
      $display("FAIL mix_mid: got no o_mix_valid, expected 1234");
    end else begin
      a = act_mix_q.pop_front();
      void'(exp_mix_q.pop_front());
      if (a !== 16'h1234) begin n_fail++; $display("FAIL mix_mid: got %h, expected 1234", a); end
    end
    wait_frames(2, 1500);
    n_cmp++;
    if (act_frame_q.size() < 2) begin
      n_fail++;
      $display("FAIL frame_mid: got %0d frames, expected 2", act_frame_q.size());
    end else begin
      f = act_frame_q.pop_front();
      if (f !== frame_of(16'ha5c3)) begin
        n_fail++;
        $display("FAIL frame_mid_old: got %h, expected %h", f, frame_of(16'ha5c3));
      end
      n_cmp++;
      f = act_frame_q.pop_front();
      if (f !== frame_of(16'h1234)) begin
        n_fail++;
        $display("FAIL frame_mid_new: got %h, expected %h", f, frame_of(16'h1234));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [15:0] a;
    logic [31:0] f;
    while (!(aligned && dacdat === 1'b1) && n < 600) begin
      @(negedge clk);
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mix, mix_valid, busy, overflow, dropped, dacdat} !== 21'b0) begin
      n_fail++;
      $display("FAIL reset_serial: got %h, expected 0",
               {mix, mix_valid, busy, overflow, dropped, dacdat});
    end
    codec_en = 0;
    bclk = 1'b0;
    lrck = 1'b0;
    aligned = 0;
    falls = 0;
    div = 0;
    act_frame_q.delete();
    act_mix_q.delete();
    exp_mix_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_pulse({16'd0, 16'd0, 16'd7, 16'd9});
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mix, mix_valid, busy, overflow, dropped} !== 20'b0) begin
      n_fail++;
      $display("FAIL reset_accum: got %h, expected 0", {mix, mix_valid, busy, overflow, dropped});
    end
    exp_mix_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (act_mix_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_partial: got %0d pulses, expected 0", act_mix_q.size());
    end
    act_mix_q.delete();
    drive_pulse({16'd0, 16'd0, 16'd0, 16'ha5c3});
    wait_mix();
    n_cmp++;
    if (act_mix_q.size() == 0) begin
      n_fail++;
      $display("FAIL mix_post_reset: got no o_mix_valid, expected a5c3");
    end else begin
      a = act_mix_q.pop_front();
      void'(exp_mix_q.pop_front());
      if (a !== 16'ha5c3) begin n_fail++; $display("FAIL mix_post_reset: got %h, expected a5c3", a); end
    end
    codec_en = 1;
    wait_frames(1, 1500);
    n_cmp++;
    if (act_frame_q.size() == 0) begin
      n_fail++;
      $display("FAIL frame_post_reset: got no frame, expected %h", frame_of(16'ha5c3));
    end else begin
      f = act_frame_q.pop_front();
      if (f !== frame_of(16'ha5c3)) begin
        n_fail++;
        $display("FAIL frame_post_reset: got %h, expected %h", f, frame_of(16'ha5c3));
      end
    end
    codec_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_dropped();
    test_framing();
    test_midframe();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/effect_mixer.md
# effect_mixer

Downstream consumer of the per-button sound-effect stages. It sums NUM_CH signed 16-bit effect samples once per playback tick, then saturates the sum to 16 bits. It holds the result and serializes it MSB-first to the WM8731 DAC data pin, in I2S framing, on both LRCK phases (mono to both channels). It replaces direct wiring of a single effect output to the DAC, so that several simultaneous button sounds play together without wrap-around distortion.

## Interface
Parameters:
- NUM_CH, 4: number of effect channels mixed; legal range 1..8.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_sample_valid  input  1  one-cycle pulse: the current playback-tick samples on i_samples are valid.
- i_samples  input  NUM_CH*16  channel k, signed two's complement, at bits [16k+15:16k].
- i_AUD_BCLK  input  1  codec bit clock; asynchronous to i_clk.
- i_AUD_DACLRCK  input  1  codec DAC LR clock; asynchronous to i_clk.
- o_AUD_DACDAT  output  1  serial DAC data.
- o_mix  output  16  last saturated mix, signed.
- o_mix_valid  output  1  one-cycle pulse when o_mix updates.
- o_busy  output  1  high while the mix FSM is not IDLE.
- o_overflow  output  1  sticky: some mix was clamped.
- o_dropped  output  1  sticky: an i_sample_valid arrived while busy.

## Operation
- Mix FSM has three states:
  - IDLE: on i_sample_valid, latch all channels into a sample register, clear the accumulator, set idx=0, go to ACCUM.
  - ACCUM: each cycle, add sign-extended channel[idx] to a 20-bit signed accumulator and increment idx. After the add of idx=NUM_CH-1, go to SAT.
  - SAT: clamp the accumulator. If acc > 32767, result = 32767. If acc < -32768, result = -32768. Otherwise result = acc[15:0].
    - Write the result to o_mix and to the DAC holding register.
    - Pulse o_mix_valid.
    - Set o_overflow if clamping occurred.
    - Return to IDLE.
- i_sample_valid in ACCUM or SAT: the pulse is ignored, o_dropped is set, and the in-flight mix is unaffected.
- Sticky flags clear only on reset.
- DAC path:
  - i_AUD_BCLK and i_AUD_DACLRCK each pass through a 2-flop synchronizer.
  - Edges are detected on the synchronized versions.
  - On any synchronized LRCK edge (rising or falling): load the 16-bit shift register from the holding register, and set the bit counter to 0.
  - On the first synchronized BCLK falling edge after the LRCK edge, drive bit 15 (I2S one-BCLK delay).
  - On each subsequent BCLK falling edge, drive the next lower bit.
  - After bit 0 has been driven for one BCLK period, the next falling edge drives 0 until the next LRCK edge.
  - If the holding register updates mid-frame, the current frame is unaffected. The new value appears from the next LRCK edge.
  - If an LRCK edge and a BCLK falling edge are detected in the same cycle, the LRCK load takes priority and the BCLK edge is not counted.

## Timing
- Reset values:
  - Mix FSM is IDLE; accumulator, idx and sample register are 0.
  - o_mix = 0, o_mix_valid = 0, o_busy = 0, o_overflow = 0, o_dropped = 0.
  - Holding register, shift register and bit counter are 0; o_AUD_DACDAT = 0.
  - Synchronizer flops are 0.
- Reset asserted mid-mix or mid-frame: every register returns to its reset value immediately; no partial output.
- Latency: i_sample_valid is sampled at edge 0, and o_mix_valid is high in the cycle after edge NUM_CH+1. That is NUM_CH+2 cycles from pulse to valid.
- o_busy is high from the cycle after edge 0 through the SAT cycle inclusive.
- Minimum back-to-back i_sample_valid spacing without a drop is NUM_CH+2 cycles.
- Synchronized-edge detection lags the pin by 2-3 i_clk cycles.
- The design requires i_clk ≥ 4× BCLK frequency. o_AUD_DACDAT changes 2-3 i_clk cycles after the BCLK falling pin edge.
- Arithmetic:
  - 20-bit accumulator; sign-extend each 16-bit sample.
  - No intermediate saturation; clamp only in SAT.

## Test plan
- NUM_CH=4, samples 100, -50, 25, 0, one pulse -> o_mix_valid at 6 cycles after the pulse; o_mix=75; o_overflow=0.
- Samples 30000, 30000, 0, 0 -> o_mix=32767, o_overflow=1. Then samples -30000, -30000, -30000, 0 -> o_mix=-32768, o_overflow still 1.
- Second i_sample_valid 3 cycles after the first -> first mix completes with the correct value, o_dropped=1, and no second o_mix_valid pulse.
- Holding register = 16'hA5C3, BCLK at i_clk/8, LRCK toggles every 32 BCLK:
  - o_AUD_DACDAT, sampled on BCLK rising edges, is 0 in slot 0, then 1010010111000011 in slots 1-16, then 0 until the next LRCK edge.
  - The same pattern repeats on the opposite LRCK phase.
- Update the mix mid-frame (at BCLK 8) -> the current frame completes with the old value; the next LRCK frame carries the new value.
- Assert i_rst_n low during ACCUM and during serialization -> all outputs are 0 within the reset; after release, one new pulse produces a correct mix and framing.
